// File: rtl/fifo_blk_fetch_pkg.sv
// Shared definitions for the FIFO block controllers.
// Holds the fill/hold state encoding and the default word and block geometry.
// The write-side controller uses the same definitions.
package fifo_blk_fetch_pkg;

  localparam int unsigned DefDwidth = 32;
  localparam int unsigned DefWords  = 4;

  typedef enum logic {
    StFill,
    StHold
  } blk_state_e;

endpackage

// File: rtl/fifo_blk_fetch.sv
// Read-side block fetcher for the asynchronous word FIFO.
// It paces FIFO reads in the rclk domain and packs WORDS consecutive words into one block.
// The first word read lands in the MSBs of the block.
// Each block is offered to the core through a valid/ready handshake.
//
// Ports:
//   rclk, arst_n   read-side clock and asynchronous active-low reset
//   clr            synchronous flush of any partial or offered block
//   rempty, rrq    FIFO empty flag in, FIFO read request out
//   rdata          FIFO read data, valid the cycle after an accepted read
//   blk_valid      a complete block is offered; paired with blk_ready
//   blk_ready      the core accepts the offered block
//   blk_data       the packed block
//   busy           a block is partially collected or is being offered
module fifo_blk_fetch
  import fifo_blk_fetch_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned WORDS  = DefWords
) (
  input  logic                    rclk,
  input  logic                    arst_n,
  input  logic                    clr,
  input  logic                    rempty,
  output logic                    rrq,
  input  logic [DWIDTH-1:0]       rdata,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [DWIDTH*WORDS-1:0] blk_data,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(WORDS + 1);
  localparam int unsigned BlkW = DWIDTH * WORDS;
  localparam logic [CntW-1:0] WordsCnt = CntW'(WORDS);
  localparam logic [CntW-1:0] LastCnt  = CntW'(WORDS - 1);

  blk_state_e      state_q, state_d;
  logic [CntW-1:0] iss_q, iss_d;   // reads issued to the FIFO
  logic [CntW-1:0] cap_q, cap_d;   // words captured into sreg
  logic            pend_q, pend_d; // a read was accepted last cycle; rdata is live
  logic [BlkW-1:0] sreg_q, sreg_d;

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StFill;
      iss_q   <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    pend_d  = pend_q;
    sreg_d  = sreg_q;
    if (clr) begin
      // Flush wins over capture and handshake; an in-flight word is dropped.
      state_d = StFill;
      iss_d   = '0;
      cap_d   = '0;
      pend_d  = 1'b0;
      sreg_d  = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          pend_d = rrq;
          if (rrq) begin
            iss_d = iss_q + 1'b1;
          end
          if (pend_q) begin
            sreg_d = {sreg_q[BlkW-DWIDTH-1:0], rdata};
            cap_d  = cap_q + 1'b1;
            if (cap_q == LastCnt) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (blk_ready) begin
            state_d = StFill;
            iss_d   = '0;
            cap_d   = '0;
            pend_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    // The iss bound stops the block from popping more than WORDS words.
    rrq       = (state_q == StFill) && !rempty && (iss_q < WordsCnt) && !clr;
    blk_valid = (state_q == StHold);
    busy      = (iss_q != '0) || (state_q == StHold);
    blk_data  = sreg_q;
  end

endmodule

// File: doc/fifo_blk_fetch.md
# fifo_blk_fetch

Read-side controller for the asynchronous word FIFO: sequences FIFO reads in the `rclk` domain and packs `WORDS` consecutive `DWIDTH`-bit words into one block for the AES core. It sits between the FIFO read port (`rrq`/`rempty`/`rdata`) and the core's block input, and presents each block through a valid/ready handshake. It owns all FIFO read pacing, so the core never touches `rrq`.

## Interface
- `DWIDTH`, 32, FIFO word width.
- `WORDS`, 4, words per block. Must be ≥ 2. The block width is `DWIDTH*WORDS`, which is 128 by default.
- `rclk`  in  1  sole clock, the FIFO read-side clock.
- `arst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush of any partial block, active high.
- `rempty`  in  1  FIFO empty flag.
- `rrq`  out  1  FIFO read request.
- `rdata`  in  `DWIDTH`  FIFO read data. It is valid in the cycle after an accepted read.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  the core accepts the block.
- `blk_data`  out  `DWIDTH*WORDS`  packed block. The first word read occupies the MSBs.
- `busy`  out  1  high while a block is partially collected or in flight.

## Operation
- **States:**
  - FILL: collecting words.
  - HOLD: a block is complete and offered.
- **Counters:** `iss` counts reads issued and `cap` counts words captured. Both run 0..`WORDS` and are `$clog2(WORDS+1)` bits wide.
- **Read request:** `rrq = (state==FILL) && !rempty && (iss<WORDS) && !clr`. The request is combinational from the registered state and counters.
- **Accepted read:** any cycle with `rrq` high. It increments `iss` and sets the registered flag `pend`.
- **Capture:** when `pend` is set, `rdata` is sampled at the next edge. The shift register updates as `sreg <= {sreg[DWIDTH*WORDS-DWIDTH-1:0], rdata}` and `cap` increments.
- **Block complete:** at the edge where `cap` goes from `WORDS-1` to `WORDS`, the block is complete. At that edge:
  - the state moves to HOLD;
  - `blk_valid` goes to 1;
  - `blk_data` equals `sreg` after the update.
- **HOLD:**
  - `rrq` stays 0.
  - `blk_data` is stable until the handshake completes.
  - When `blk_valid && blk_ready`, the state returns to FILL, `iss`, `cap` and `pend` clear, and `blk_valid` drops at that edge.
- **Stalls:** `rempty` going high mid-block only stalls `rrq`. A partial block is retained indefinitely, with no timeout.
- **`clr`:**
  - Clears `iss`, `cap`, `pend`, `blk_valid` and `sreg` at the next edge, from any state.
  - A word in flight (`pend` set) is discarded.
  - `clr` wins over a simultaneous `blk_ready` handshake and over a capture.
  - The state goes to FILL.
- **`busy`:** `(iss!=0) || (state==HOLD)`.
- **Overflow protection:** `iss` never exceeds `WORDS`, so no extra word is popped.

## Timing
- **Reset values:**
  - `rrq`=0, `blk_valid`=0, `blk_data`=0, `busy`=0;
  - state FILL, `iss`=`cap`=0, `pend`=0.
- **Latency, with the FIFO holding at least `WORDS` words and `blk_ready` high:**
  - `rrq` is high in cycles t..t+WORDS-1;
  - words are captured at the edges ending cycles t+1..t+WORDS;
  - `blk_valid` is high from cycle t+WORDS+1.
- **Throughput:** the handshake edge re-enters FILL and `rrq` can assert in the following cycle, giving one block every `WORDS+2` cycles.
- **Reset mid-operation:** `arst_n` asserted mid-operation clears everything immediately. Words already popped are lost, and the FIFO is reset by the same `arst_n`.

## Structure
- **Shared package:** the state enum (FILL, HOLD) and the default `DWIDTH`/`WORDS` constants go in the controller package, shared with the write-side controller.
- **Module boundaries:** single module, with no sub-module. The shift register and counters are small enough to stay inline. The FIFO is instantiated by the parent, not inside this block.

## Test plan
- **Back-to-back block:** reset, FIFO preloaded with 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, `blk_ready`=1. Required response:
  - `rrq` high for 4 cycles;
  - `blk_valid` high in cycle 6 (t+5, counting the first `rrq` cycle as t+0) with `blk_data`=0x00112233_44556677_8899AABB_CCDDEEFF;
  - single-cycle `blk_valid`.
- **Starved FIFO:** `rempty` high after word 2 for 10 cycles. Required response:
  - `rrq` low during the gap;
  - `busy`=1;
  - `blk_valid` only after words 3 and 4 arrive, with order preserved.
- **Backpressure:** `blk_ready`=0 for 8 cycles after a block completes. Required response:
  - `blk_data` constant;
  - `rrq`=0 throughout, even with the FIFO non-empty;
  - one cycle after `blk_ready` rises, `rrq` resumes for the next block.
- **Flush:** pulse `clr` after 2 words, with word 3 in flight. Required response:
  - next cycle `busy`=0;
  - the next `blk_data` consists solely of words 4..7.
- **Simultaneous `clr` and `blk_ready` in HOLD:** required response is `blk_valid`=0 and `cap`=0, with no double pop.
- **Reset mid-block:** assert `arst_n`=0 after 3 captures. Required response:
  - all outputs 0 immediately;
  - after release, the first block uses fresh words.
